// File: rtl/ysyx_23060042_ctrl.sv
// Multi-cycle control FSM: sequences fetch, decode, execute, memory and write-back,
// owns pc and the retired-instruction counter, and traps on ebreak, timeout or misaligned target.
module ysyx_23060042_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h80000000,
  parameter logic [7:0]  TIMEOUT  = 8'd255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ifu_rvalid,
  input  logic        lsu_done,
  input  logic        is_load,
  input  logic        is_store,
  input  logic        inst_wen,
  input  logic        brchen,
  input  logic [31:0] brch_target,
  input  logic        brken,
  output logic [31:0] pc,
  output logic        ifu_req,
  output logic        inst_latch,
  output logic        exu_valid,
  output logic        lsu_req,
  output logic        rf_wen,
  output logic        halted,
  output logic        err,
  output logic [2:0]  state,
  output logic [31:0] instret
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5,
    S_ERROR  = 3'd6,
    S_BAD    = 3'd7
  } state_t;

  state_t      cur;
  logic [31:0] pc_q;
  logic [31:0] instret_q;
  logic [7:0]  wait_cnt;
  logic        brch_q;
  logic [31:0] target_q;
  logic        timeout_hit;

  // Handshake: a request (ifu_req / lsu_req) stays high until its acknowledge
  // (ifu_rvalid / lsu_done) is sampled high on a rising edge in the matching
  // state; acknowledges seen in any other state have no effect.
  assign timeout_hit = ({1'b0, wait_cnt} + 9'd1) >= {1'b0, TIMEOUT};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cur       <= S_FETCH;
      pc_q      <= RESET_PC;
      instret_q <= '0;
      wait_cnt  <= '0;
      brch_q    <= 1'b0;
      target_q  <= '0;
    end else begin
      case (cur)
        S_FETCH: begin
          if (ifu_rvalid) begin
            cur      <= S_DECODE;
            wait_cnt <= '0;
          end else if (timeout_hit) begin
            cur      <= S_ERROR;
            wait_cnt <= '0;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        S_DECODE: cur <= S_EXEC;
        S_EXEC: begin
          brch_q   <= brchen;
          target_q <= brch_target;
          if (brken) begin
            cur       <= S_HALT;
            instret_q <= instret_q + 32'd1;
          end else if (brchen && (brch_target[1:0] != 2'b00)) begin
            cur <= S_ERROR;
          end else if (is_load || is_store) begin
            cur <= S_MEM;
          end else begin
            cur <= S_WB;
          end
        end
        S_MEM: begin
          if (lsu_done) begin
            cur      <= S_WB;
            wait_cnt <= '0;
          end else if (timeout_hit) begin
            cur      <= S_ERROR;
            wait_cnt <= '0;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        S_WB: begin
          pc_q      <= brch_q ? target_q : pc_q + 32'd4;
          instret_q <= instret_q + 32'd1;
          cur       <= S_FETCH;
        end
        S_HALT:  cur <= S_HALT;
        S_ERROR: cur <= S_ERROR;
        default: cur <= S_ERROR;
      endcase
    end
  end

  // ifu_req is qualified by rst so it drops asynchronously in reset and
  // rises as soon as reset is released.
  assign ifu_req    = rst && (cur == S_FETCH);
  assign inst_latch = ifu_req && ifu_rvalid;
  assign exu_valid  = (cur == S_EXEC);
  assign lsu_req    = (cur == S_MEM);
  assign rf_wen     = (cur == S_WB) && inst_wen && !is_store;
  assign halted     = (cur == S_HALT);
  assign err        = (cur == S_ERROR);
  assign state      = cur;
  assign pc         = pc_q;
  assign instret    = instret_q;

endmodule

// File: tb/tb_ysyx_23060042_ctrl.sv
// Directed bench for ysyx_23060042_ctrl: stimulus pushes expected fetch/write-back/trap
// records into a queue, a negedge monitor pops and compares them as the DUT shows each event.
module tb_ysyx_23060042_ctrl;

  localparam logic [31:0] RST_PC = 32'h80000000;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        ifu_rvalid = 1'b0;
  logic        lsu_done = 1'b0;
  logic        is_load = 1'b0;
  logic        is_store = 1'b0;
  logic        inst_wen = 1'b0;
  logic        brchen = 1'b0;
  logic [31:0] brch_target = '0;
  logic        brken = 1'b0;
  logic [31:0] pc;
  logic        ifu_req;
  logic        inst_latch;
  logic        exu_valid;
  logic        lsu_req;
  logic        rf_wen;
  logic        halted;
  logic        err;
  logic [2:0]  state;
  logic [31:0] instret;

  ysyx_23060042_ctrl dut (
    .clk(clk), .rst(rst), .ifu_rvalid(ifu_rvalid), .lsu_done(lsu_done),
    .is_load(is_load), .is_store(is_store), .inst_wen(inst_wen), .brchen(brchen),
    .brch_target(brch_target), .brken(brken), .pc(pc), .ifu_req(ifu_req),
    .inst_latch(inst_latch), .exu_valid(exu_valid), .lsu_req(lsu_req), .rf_wen(rf_wen),
    .halted(halted), .err(err), .state(state), .instret(instret)
  );

  // clock / reset
  always #5 clk = ~clk;

  int          n_vec = 0;
  int          n_bad = 0;
  logic [67:0] exp_q[$];
  logic        term_seen = 1'b0;
  logic [31:0] m_pc = RST_PC;
  logic [31:0] m_ret = '0;

  task automatic chk(input string name, input logic [67:0] act, input logic [67:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // record = {kind(0 fetch,1 wb,2 trap), pc, instret, flags}
  function automatic logic [67:0] rec(input logic [1:0] k, input logic [31:0] p,
                                      input logic [31:0] r, input logic [1:0] f);
    return {k, p, r, f};
  endfunction

  task automatic sb_pop(input string name, input logic [67:0] act);
    if (exp_q.size() == 0) begin
      n_vec++;
      n_bad++;
      $display("FAIL %s: unexpected event %h, expected none", name, act);
    end else begin
      chk(name, act, exp_q.pop_front());
    end
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    if (!rst) begin
      term_seen = 1'b0;
    end else begin
      if (inst_latch) sb_pop("fetch", rec(2'd0, pc, instret, 2'b00));
      if (state == 3'd4) sb_pop("wb", rec(2'd1, pc, instret, {rf_wen, 1'b0}));
      if ((halted || err) && !term_seen) begin
        term_seen = 1'b1;
        sb_pop("trap", rec(2'd2, pc, instret, {halted, err}));
      end
    end
  end

  // driver tasks
  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b0;
    #2;
    chk("reset_regs", {2'd0, pc, instret, halted, err}, rec(2'd0, RST_PC, 32'd0, 2'b00));
    chk("reset_ctl", {60'd0, state, ifu_req, inst_latch, exu_valid, lsu_req, rf_wen}, 68'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("release_req", 68'(ifu_req), 68'd1);
    m_pc  = RST_PC;
    m_ret = '0;
  endtask

  // Drives one instruction from a fresh FETCH cycle until FETCH/HALT/ERROR.
  task automatic issue(input string nm, input logic ld, input logic st, input logic wen,
                       input logic br, input logic [31:0] tgt, input logic brk,
                       input int mem_wait, output int lat, output int lsu_cyc);
    int   mcnt = 0;
    logic done = 1'b0;
    is_load = ld; is_store = st; inst_wen = wen;
    brchen = br; brch_target = tgt; brken = brk;
    ifu_rvalid = 1'b1;
    exp_q.push_back(rec(2'd0, m_pc, m_ret, 2'b00));
    if (brk) begin
      m_ret = m_ret + 32'd1;
      exp_q.push_back(rec(2'd2, m_pc, m_ret, 2'b10));
    end else if (br && (tgt[1:0] != 2'b00)) begin
      exp_q.push_back(rec(2'd2, m_pc, m_ret, 2'b01));
    end else begin
      exp_q.push_back(rec(2'd1, m_pc, m_ret, {wen & ~st, 1'b0}));
      m_pc  = br ? tgt : m_pc + 32'd4;
      m_ret = m_ret + 32'd1;
    end
    lat = 0;
    lsu_cyc = 0;
    while (!done && lat < 64) begin
      @(posedge clk); #1;
      lat++;
      if (lsu_req) lsu_cyc++;
      if (state == 3'd3) begin
        mcnt++;
        lsu_done = (mcnt > mem_wait);
      end else begin
        lsu_done = 1'b0;
      end
      if (state == 3'd0 || state == 3'd5 || state == 3'd6) done = 1'b1;
    end
    if (!done) chk({nm, "_bound"}, 68'd0, 68'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time exceeded, expected completion");
    $fatal(1);
  end

  initial begin
    int   lat;
    int   lc;
    int   n;
    logic bad;
    logic found;

    ifu_rvalid = 1'b1;
    do_reset();

    for (int i = 0; i < 3; i++) begin
      issue($sformatf("plain%0d", i), 1'b0, 1'b0, 1'b1, 1'b0, 32'd0, 1'b0, 0, lat, lc);
      chk("plain_lat", 68'(lat), 68'd4);
    end
    chk("plain_pc", 68'(pc), 68'h8000000c);
    chk("plain_instret", 68'(instret), 68'd3);

    issue("load", 1'b1, 1'b0, 1'b1, 1'b0, 32'd0, 1'b0, 3, lat, lc);
    chk("load_lsu_req", 68'(lc), 68'd4);
    chk("load_lat", 68'(lat), 68'd8);
    chk("load_pc", 68'(pc), 68'h80000010);

    issue("store", 1'b0, 1'b1, 1'b1, 1'b0, 32'd0, 1'b0, 0, lat, lc);
    chk("store_lat", 68'(lat), 68'd5);
    chk("store_lsu_req", 68'(lc), 68'd1);

    issue("ebreak", 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b1, 0, lat, lc);
    chk("ebreak_lat", 68'(lat), 68'd3);
    lsu_done = 1'b1;
    bad = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (ifu_req || lsu_req || exu_valid || rf_wen || inst_latch || state != 3'd5 ||
          instret != 32'd6 || pc != 32'h80000014 || !halted)
        bad = 1'b1;
    end
    chk("halt_hold", 68'(bad), 68'd0);
    lsu_done = 1'b0;

    do_reset();
    issue("br_ok", 1'b0, 1'b0, 1'b0, 1'b1, 32'h80000100, 1'b0, 0, lat, lc);
    chk("br_lat", 68'(lat), 68'd4);
    chk("br_pc", 68'(pc), 68'h80000100);
    issue("after_br", 1'b0, 1'b0, 1'b1, 1'b0, 32'd0, 1'b0, 0, lat, lc);
    issue("br_mis", 1'b0, 1'b0, 1'b1, 1'b1, 32'h80000102, 1'b0, 0, lat, lc);
    chk("mis_lat", 68'(lat), 68'd3);
    repeat (3) @(posedge clk);
    #1;
    chk("mis_hold", {3'd0, state, err, pc, instret}, {3'd0, 3'd6, 1'b1, 32'h80000104, 32'd2});

    ifu_rvalid = 1'b0;
    brchen = 1'b0;
    do_reset();
    exp_q.push_back(rec(2'd2, RST_PC, 32'd0, 2'b01));
    n = 0;
    found = 1'b0;
    while (!found && n < 400) begin
      @(posedge clk); #1;
      n++;
      if (state == 3'd6) found = 1'b1;
    end
    chk("timeout_cycles", 68'(n), 68'd255);

    ifu_rvalid = 1'b0;
    do_reset();
    is_load = 1'b1;
    inst_wen = 1'b1;
    exp_q.push_back(rec(2'd0, RST_PC, 32'd0, 2'b00));
    repeat (254) @(posedge clk);
    #1;
    ifu_rvalid = 1'b1;
    @(posedge clk); #1;
    chk("late_ack", {64'd0, state, err}, {64'd0, 3'd1, 1'b0});
    n = 0;
    while (state != 3'd3 && n < 10) begin
      @(posedge clk); #1;
      n++;
    end
    repeat (2) @(posedge clk);
    #1;
    chk("mem_wait_req", {64'd0, state, lsu_req}, {64'd0, 3'd3, 1'b1});
    rst = 1'b0;
    #1;
    chk("mem_reset", {1'd0, state, lsu_req, rf_wen, pc, instret}, {1'd0, 3'd0, 1'b0, 1'b0, RST_PC, 32'd0});
    lsu_done = 1'b1;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    chk("mem_release_req", 68'(ifu_req), 68'd1);
    m_pc  = RST_PC;
    m_ret = '0;
    issue("restart", 1'b0, 1'b0, 1'b1, 1'b0, 32'd0, 1'b0, 0, lat, lc);
    ifu_rvalid = 1'b0;
    chk("restart_lat", 68'(lat), 68'd4);
    chk("restart_pc", 68'(pc), 68'h80000004);

    repeat (3) @(posedge clk);
    chk("drain", 68'(exp_q.size()), 68'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
